interval_timer: RTL and testbench
=================================

// Module: interval_timer
// PURPOSE
// - Countdown timer serving the traffic-light controller's timer interface.
// - Receives interval and start_timer from the controller and returns expired.
// - Holds three programmable durations: t_base, t_ext and t_yel.
// - Derives a 1-second tick from the system clock with an internal prescaler.
// PARAMETERS
// - TICK_DIV  100_000_000  clock cycles per 1 s tick (>=2)
// - T_BASE    6            reset/default t_base, seconds
// - T_EXT     3            reset/default t_ext, seconds
// - T_YEL     2            reset/default t_yel, seconds
// PORTS
// - clock          in   1  system clock; all logic on posedge
// - reset_sync     in   1  synchronous, active-high reset
// - prog_sync      in   1  program strobe; writes time_value into the register chosen by param_sel
// - param_sel      in   2  00=t_base 01=t_ext 10=t_yel 11=no write
// - time_value     in   4  duration to program, seconds
// - interval       in   2  00=t_base 01=t_ext 10=t_yel 11=t_base
// - start_timer    in   1  1-cycle load/start request
// - expired        out  1  1-cycle pulse when the interval ends
// - one_hz_enable  out  1  1-cycle tick pulse from the prescaler
// - time_left      out  4  remaining seconds; 0 when idle
// BEHAVIOUR
// - Reset values
//   - t_base/t_ext/t_yel = T_BASE/T_EXT/T_YEL; prescaler = 0; count = 0.
//   - expired = 0; one_hz_enable = 0; time_left = 0; state = KICK.
// - States
//   - KICK: expired=1 for exactly one cycle, then IDLE. Restarts the controller after reset or programming.
//   - IDLE: count holds 0; start_timer -> RUN.
//   - RUN: counts down; reaching 0 pulses expired -> IDLE.
// - Programming
//   - While prog_sync=1: the write occurs on every cycle; any run is aborted; state = KICK_WAIT.
//   - KICK_WAIT -> KICK on the first cycle with prog_sync=0.
//   - A time_value of 0 is stored as 1.
//   - start_timer is ignored while prog_sync=1.
// - Start (outside programming)
//   - count <= selected register; prescaler <= 0; state RUN, next cycle.
//   - A start during RUN restarts the interval. A start in KICK is accepted.
// - Prescaler
//   - Increments each cycle in RUN only.
//   - At TICK_DIV-1: wraps to 0 and pulses one_hz_enable; count decrements.
// - Expiry
//   - The tick that moves count 1->0 sets expired=1 on the following cycle; state -> IDLE.
// - Latency
//   - Interval of N s: expired rises N*TICK_DIV+1 cycles after the start_timer edge.
// - Simultaneous events
//   - reset_sync over prog_sync over start_timer over tick.
//   - start_timer on the same cycle as the final tick: restart wins, no expired pulse.
//   - prog_sync write and start_timer selecting the same register: prog_sync wins and the start is dropped.
// - reset_sync mid-run: abort the run; restore defaults; issue KICK after release.
// - time_left mirrors count, registered.
// CONFIGURATION
// - TIMER_FAST_SIM_EN defined:
//   - Prescaler removed; one_hz_enable = 1 every cycle in RUN.
//   - N s interval expires N+1 cycles after start.
// - Not defined: TICK_DIV prescaler as above.
// TESTING
// - Reset release: expired pulses once in the cycle after reset_sync falls; time_left=0.
// - Base interval (FAST_SIM): start_timer with interval=00 -> time_left 6,5,..,1; expired at cycle 7; one pulse only.
// - Programming: prog_sync with param_sel=01, time_value=9, then start with interval=01 -> expiry after 9 ticks; single KICK pulse after prog_sync falls.
// - Programming 0: param_sel=10, time_value=0 -> t_yel=1 -> expired 2 cycles after start (FAST_SIM).
// - Restart: start at cycle 0; second start at cycle 3 with interval=10 (t_yel=2) -> single expired pulse 3 cycles after the second start.
// - Mid-run reset: reset_sync at time_left=2 -> no interval expiry; defaults restored; KICK pulse after release.

Source files
------------

// File: rtl/interval_timer.sv
// Countdown interval timer for the traffic-light controller, with three programmable durations and a 1 s prescaler.
// Define TIMER_FAST_SIM_EN to remove the prescaler so that every RUN cycle is one tick.
module interval_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int T_BASE   = 6,
  parameter int T_EXT    = 3,
  parameter int T_YEL    = 2
) (
  input  logic       clock,
  input  logic       reset_sync,
  input  logic       prog_sync,
  input  logic [1:0] param_sel,
  input  logic [3:0] time_value,
  input  logic [1:0] interval,
  input  logic       start_timer,
  output logic       expired,
  output logic       one_hz_enable,
  output logic [3:0] time_left
);

  typedef enum logic [1:0] {KICK, KICK_WAIT, IDLE, RUN} state_t;

  state_t     state, state_nxt;
  logic [3:0] t_base, t_ext, t_yel;
  logic [3:0] count, count_nxt, sel_time, prog_val;
  logic       tick, expire, load, kick;

  // Start is refused while programming and during the cycle prog_sync drops.
  assign load     = !prog_sync && start_timer && (state != KICK_WAIT);
  assign kick     = !prog_sync && (state == KICK);
  assign prog_val = (time_value == 4'd0) ? 4'd1 : time_value;

`ifdef TIMER_FAST_SIM_EN
  assign tick = (state == RUN) && (count != 4'd0);
`else
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] prescaler;
  logic          wrap;

  assign wrap = (prescaler == PW'(TICK_DIV - 1));
  assign tick = (state == RUN) && (count != 4'd0) && wrap;

  always_ff @(posedge clock) begin
    if (reset_sync || prog_sync || load || state != RUN) prescaler <= '0;
    else if (wrap)                                          prescaler <= '0;
    else                                                    prescaler <= prescaler + 1'b1;
  end
`endif

  always_comb begin
    sel_time = t_base;
    case (interval)
      2'b01:   sel_time = t_ext;
      2'b10:   sel_time = t_yel;
      default: sel_time = t_base;
    endcase
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    expire    = 1'b0;
    if (prog_sync) begin
      state_nxt = KICK_WAIT;
      count_nxt = 4'd0;
    end else begin
      case (state)
        KICK_WAIT: state_nxt = KICK;
        KICK:      state_nxt = IDLE;
        RUN: begin
          // count reached 0 on the previous tick; this cycle ends the interval
          if (count == 4'd0) begin
            expire    = 1'b1;
            state_nxt = IDLE;
          end else if (tick) begin
            count_nxt = count - 4'd1;
          end
        end
        default: ;
      endcase
      if (load) begin
        state_nxt = RUN;
        count_nxt = sel_time;
        expire    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_sync) begin
      state         <= KICK;
      count         <= 4'd0;
      expired       <= 1'b0;
      one_hz_enable <= 1'b0;
      t_base        <= 4'(T_BASE);
      t_ext         <= 4'(T_EXT);
      t_yel         <= 4'(T_YEL);
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      expired       <= kick | expire;
      one_hz_enable <= tick & ~load & ~prog_sync;
      if (prog_sync) begin
        case (param_sel)
          2'b00:   t_base <= prog_val;
          2'b01:   t_ext  <= prog_val;
          2'b10:   t_yel  <= prog_val;
          default: ;
        endcase
      end
    end
  end

  assign time_left = count;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: directed scenarios then random traffic, checked each cycle against a deadline-based model.
module tb_interval_timer;
  localparam int TD = 3;
`ifdef TIMER_FAST_SIM_EN
  localparam int TDM = 1;
`else
  localparam int TDM = TD;
`endif

  logic       clock = 1'b0;
  logic       reset_sync, prog_sync, start_timer;
  logic [1:0] param_sel, interval;
  logic [3:0] time_value;
  logic       expired, one_hz_enable;
  logic [3:0] time_left;

  int vectors = 0, miscompares = 0;

  // reference model: durations plus the start edge and length of the active interval
  int  mt_base, mt_ext, mt_yel;
  bit  mrun, mkick_next, mkick_wait;
  int  ms, mn, cyc = 0;

  interval_timer #(.TICK_DIV(TD), .T_BASE(6), .T_EXT(3), .T_YEL(2)) dut (
    .clock(clock), .reset_sync(reset_sync), .prog_sync(prog_sync), .param_sel(param_sel),
    .time_value(time_value), .interval(interval), .start_timer(start_timer),
    .expired(expired), .one_hz_enable(one_hz_enable), .time_left(time_left)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic [1:0] ps, input logic [3:0] tv,
                      input logic [1:0] iv, input logic st);
    bit e_exp, e_tick, was_wait;
    int e_left, el, v;
    reset_sync = r; prog_sync = p; param_sel = ps; time_value = tv; interval = iv; start_timer = st;
    @(posedge clock);
    cyc++;
    e_exp = 0; e_tick = 0;
    if (r) begin
      mt_base = 6; mt_ext = 3; mt_yel = 2;
      mrun = 0; mkick_next = 1; mkick_wait = 0;
    end else if (p) begin
      v = (tv == 0) ? 1 : int'(tv);
      case (ps)
        2'd0: mt_base = v;
        2'd1: mt_ext = v;
        2'd2: mt_yel = v;
        default: ;
      endcase
      mrun = 0; mkick_wait = 1; mkick_next = 0;
    end else begin
      was_wait = mkick_wait;
      e_exp = mkick_next;
      mkick_next = 0;
      if (mkick_wait) begin mkick_wait = 0; mkick_next = 1; end
      if (st && !was_wait) begin
        mrun = 1; ms = cyc;
        mn = (iv == 2'd1) ? mt_ext : (iv == 2'd2) ? mt_yel : mt_base;
      end else if (mrun) begin
        el = cyc - ms;
        if (el == mn * TDM + 1) begin e_exp = 1; mrun = 0; end
        else if (el % TDM == 0) e_tick = 1;
      end
    end
    e_left = mrun ? mn - (cyc - ms) / TDM : 0;
    @(negedge clock);
    check("expired", {3'b0, expired}, {3'b0, e_exp});
    check("one_hz_enable", {3'b0, one_hz_enable}, {3'b0, e_tick});
    check("time_left", time_left, 4'(e_left));
  endtask

  task automatic idle();
    step(0, 0, 2'd3, 4'd0, 2'd0, 0);
  endtask

  // start an interval and measure the cycles until expired is seen
  task automatic run_interval(input string tag, input logic [1:0] iv, input int n);
    int lat = -1;
    step(0, 0, 2'd3, 4'd0, iv, 1);
    for (int k = 1; k <= 16 * TDM + 8; k++) begin
      idle();
      if (expired === 1'b1) begin lat = k; break; end
    end
    vectors++;
    assert (lat == n * TDM + 1) else begin
      miscompares++;
      $error("FAIL %s latency: got %0d expected %0d", tag, lat, n * TDM + 1);
    end
  endtask

  initial begin
    // reset and the kick pulse that follows release
    repeat (3) step(1, 0, 2'd3, 4'd0, 2'd0, 0);
    check("reset_time_left", time_left, 4'd0);
    idle();
    check("kick_after_reset", {3'b0, expired}, 4'd1);
    idle();

    run_interval("base", 2'd0, 6);

    // program t_ext=9, kick follows prog release
    repeat (2) step(0, 1, 2'd1, 4'd9, 2'd0, 0);
    repeat (3) idle();
    run_interval("ext9", 2'd1, 9);

    // zero stored as one; start during prog is dropped
    step(0, 1, 2'd2, 4'd0, 2'd2, 1);
    repeat (3) idle();
    run_interval("yel0", 2'd2, 1);

    // restart mid-run with t_yel=2
    step(0, 1, 2'd2, 4'd2, 2'd0, 0);
    repeat (3) idle();
    step(0, 0, 2'd3, 4'd0, 2'd0, 1);
    repeat (2) idle();
    run_interval("restart", 2'd2, 2);

    // mid-run reset: no expiry, defaults restored
    step(0, 0, 2'd3, 4'd0, 2'd0, 1);
    for (int k = 0; k < 16 * TDM && time_left !== 4'd2; k++) idle();
    check("reached_two", time_left, 4'd2);
    repeat (2) step(1, 0, 2'd3, 4'd0, 2'd0, 0);
    repeat (6 * TDM + 4) idle();
    run_interval("ext_default", 2'd1, 3);
    run_interval("sel11_base", 2'd3, 6);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0, 2'($urandom), 4'($urandom),
           2'($urandom), $urandom_range(0, 24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
